// File: rtl/stage_m.sv
// Memory stage of the 5-stage MIPS pipeline: byte-enabled data memory, load extension and the M/W register.
// Optional macro DM_DISPLAY_EN: prints every store as a simulation trace line.
module stage_m #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrM,
  input  logic [31:0] PCM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ForwardM2,
  input  logic [31:0] WDM,
  output logic        M2Use,
  output logic [31:0] WDMFwd,
  output logic [31:0] InstrW,
  output logic [31:0] PCW,
  output logic [31:0] WDW
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // Selects and extends the addressed byte/halfword of the read word.
  function automatic logic [31:0] load_extend(input logic [5:0]  op,
                                              input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [15:0] hw;
    logic [7:0]  by;
    hw = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    by = word[7:0];
      2'd1:    by = word[15:8];
      2'd2:    by = word[23:16];
      2'd3:    by = word[31:24];
      default: by = word[7:0];
    endcase
    case (op)
      OP_LW:   load_extend = word;
      OP_LH:   load_extend = {{16{hw[15]}}, hw};
      OP_LHU:  load_extend = {16'h0000, hw};
      OP_LB:   load_extend = {{24{by[7]}}, by};
      OP_LBU:  load_extend = {24'h000000, by};
      default: load_extend = word;
    endcase
  endfunction

  // Merges store data into the old word, little-endian, leaving other bytes untouched.
  function automatic logic [31:0] store_merge(input logic [5:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  lane);
    case (op)
      OP_SW: store_merge = data;
      OP_SH: begin
        if (lane[1]) begin
          store_merge = {data[15:0], old[15:0]};
        end else begin
          store_merge = {old[31:16], data[15:0]};
        end
      end
      OP_SB: begin
        case (lane)
          2'd0:    store_merge = {old[31:8], data[7:0]};
          2'd1:    store_merge = {old[31:16], data[7:0], old[7:0]};
          2'd2:    store_merge = {old[31:24], data[7:0], old[15:0]};
          2'd3:    store_merge = {data[7:0], old[23:0]};
          default: store_merge = old;
        endcase
      end
      default: store_merge = old;
    endcase
  endfunction

  logic [5:0]       opcode_s;
  logic             is_load_s;
  logic             is_store_s;
  logic [DM_AW-1:0] word_idx_s;
  logic [1:0]       lane_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      load_val_s;
  logic [31:0]      merged_word_s;
  logic             addr_unused_s;

  logic [31:0] mem_q [DM_WORDS];
  logic [31:0] instr_w_q, instr_w_d;
  logic [31:0] pc_w_q, pc_w_d;
  logic [31:0] wd_w_q, wd_w_d;

  assign opcode_s      = InstrM[31:26];
  assign word_idx_s    = ALUOutM[DM_AW+1:2];
  assign lane_s        = ALUOutM[1:0];
  // Upper address bits are deliberately dropped so addresses wrap around the memory.
  assign addr_unused_s = ^ALUOutM[31:DM_AW+2];
  assign rd_word_s     = mem_q[word_idx_s];

  // Opcode decode into load/store classes.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    case (opcode_s)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: is_load_s  = 1'b1;
      OP_SW, OP_SH, OP_SB:                 is_store_s = 1'b1;
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

  assign load_val_s    = load_extend(opcode_s, rd_word_s, lane_s);
  assign merged_word_s = store_merge(opcode_s, rd_word_s, ForwardM2, lane_s);
  assign M2Use         = is_store_s;
  assign WDMFwd        = WDM;

  // Next-state of the M/W pipeline register.
  always_comb begin
    instr_w_d = 32'h0000_0000;
    pc_w_d    = 32'h0000_0000;
    wd_w_d    = 32'h0000_0000;
    if (Reset) begin
      instr_w_d = 32'h0000_0000;
      pc_w_d    = 32'h0000_0000;
      wd_w_d    = 32'h0000_0000;
    end else begin
      instr_w_d = InstrM;
      pc_w_d    = PCM;
      wd_w_d    = is_load_s ? load_val_s : WDM;
    end
  end

  // M/W pipeline register.
  always_ff @(posedge Clk) begin
    instr_w_q <= instr_w_d;
    pc_w_q    <= pc_w_d;
    wd_w_q    <= wd_w_d;
  end

  // Data memory: reset clears every word and wins over a concurrent store.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (is_store_s) begin
      mem_q[word_idx_s] <= merged_word_s;
    end
  end

`ifdef DM_DISPLAY_EN
  // Store trace for simulation.
  always @(posedge Clk) begin
    if (!Reset && is_store_s) begin
      $display("%d@%h: *%h <= %h", $time, PCM, {ALUOutM[31:2], 2'b00}, merged_word_s);
    end
  end
`endif

  assign InstrW = instr_w_q;
  assign PCW    = pc_w_q;
  assign WDW    = wd_w_q;

endmodule

// File: tb/tb_stage_m.sv
// Directed self-checking bench for stage_m: stores, extended loads, address wrap and reset behaviour.
module tb_stage_m;

  logic        Clk;
  logic        Reset;
  logic [31:0] InstrM, PCM, ALUOutM, ForwardM2, WDM;
  logic        M2Use;
  logic [31:0] WDMFwd, InstrW, PCW, WDW;

  int n_cmp;
  int n_err;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [31:0] ADDU  = 32'h0085_1821;

  stage_m dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .InstrM    (InstrM),
    .PCM       (PCM),
    .ALUOutM   (ALUOutM),
    .ForwardM2 (ForwardM2),
    .WDM       (WDM),
    .M2Use     (M2Use),
    .WDMFwd    (WDMFwd),
    .InstrW    (InstrW),
    .PCW       (PCW),
    .WDW       (WDW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mk(input logic [5:0] op);
    mk = {op, 5'd4, 5'd5, 16'h0000};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one instruction into M just after the falling edge.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] fwd, input logic [31:0] wdm);
    @(negedge Clk);
    InstrM    = instr;
    PCM       = pc;
    ALUOutM   = alu;
    ForwardM2 = fwd;
    WDM       = wdm;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] exp, input string tag);
    drive(mk(op), 32'h0000_0200, addr, 32'h0, 32'h0000_0BAD);
    tick();
    check_eq(tag, WDW, exp);
  endtask

  task automatic store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    drive(mk(op), 32'h0000_0300, addr, data, 32'h0000_0055);
    check_eq("store_m2use", {31'h0, M2Use}, 32'h1);
    tick();
    check_eq("store_wdw", WDW, 32'h0000_0055);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1;
    drive(mk(OP_LW), 32'h0000_0100, 32'h0, 32'h0, 32'h1111_1111);
    tick();
    check_eq("rst_instrw", InstrW, 32'h0);
    check_eq("rst_pcw", PCW, 32'h0);
    check_eq("rst_wdw", WDW, 32'h0);

    Reset = 1'b0;
    drive(mk(OP_LW), 32'h0000_0104, 32'h0, 32'h0, 32'h1111_1111);
    tick();
    check_eq("lw0_wdw", WDW, 32'h0);
    check_eq("lw0_instrw", InstrW, mk(OP_LW));
    check_eq("lw0_pcw", PCW, 32'h0000_0104);

    store(OP_SW, 32'h10, 32'h1234_5678);
    load(OP_LW, 32'h10, 32'h1234_5678, "lw_10");
    load(OP_LB, 32'h13, 32'h0000_0012, "lb_13");
    load(OP_LB, 32'h10, 32'h0000_0078, "lb_10");
    load(OP_LBU, 32'h11, 32'h0000_0056, "lbu_11");

    store(OP_SB, 32'h21, 32'hFFFF_FF80);
    load(OP_LW, 32'h20, 32'h0000_8000, "lw_20_sb");
    load(OP_LB, 32'h21, 32'hFFFF_FF80, "lb_21");
    load(OP_LBU, 32'h21, 32'h0000_0080, "lbu_21");
    store(OP_SB, 32'h23, 32'h0000_007F);
    load(OP_LW, 32'h20, 32'h7F00_8000, "lw_20_sb3");
    store(OP_SB, 32'h22, 32'h0000_00C3);
    load(OP_LW, 32'h20, 32'h7FC3_8000, "lw_20_sb2");

    store(OP_SH, 32'h32, 32'h1234_BEEF);
    load(OP_LW, 32'h30, 32'hBEEF_0000, "lw_30_sh");
    load(OP_LH, 32'h32, 32'hFFFF_BEEF, "lh_32");
    load(OP_LHU, 32'h33, 32'h0000_BEEF, "lhu_33");
    load(OP_LHU, 32'h30, 32'h0000_0000, "lhu_30");
    store(OP_SH, 32'h31, 32'h0000_7ABC);
    load(OP_LW, 32'h30, 32'hBEEF_7ABC, "lw_30_sh0");
    load(OP_LH, 32'h30, 32'h0000_7ABC, "lh_30");

    store(OP_SW, 32'h0000_1010, 32'hA5A5_A5A5);
    load(OP_LW, 32'h10, 32'hA5A5_A5A5, "lw_wrap");

    Reset = 1'b1;
    drive(mk(OP_SW), 32'h0000_0400, 32'h40, 32'hDEAD_BEEF, 32'h0000_0077);
    tick();
    check_eq("rst_sw_wdw", WDW, 32'h0);
    Reset = 1'b0;
    load(OP_LW, 32'h40, 32'h0, "lw_40_after_rst");
    load(OP_LW, 32'h10, 32'h0, "lw_10_after_rst");

    drive(ADDU, 32'h0000_0500, 32'h0000_0010, 32'h0000_1234, 32'h0000_CAFE);
    check_eq("addu_m2use", {31'h0, M2Use}, 32'h0);
    check_eq("addu_wdmfwd", WDMFwd, 32'h0000_CAFE);
    tick();
    check_eq("addu_wdw", WDW, 32'h0000_CAFE);
    check_eq("addu_instrw", InstrW, ADDU);
    check_eq("addu_pcw", PCW, 32'h0000_0500);
    load(OP_LW, 32'h10, 32'h0, "lw_10_after_addu");

    drive(mk(OP_SW), 32'h0000_0504, 32'h0, 32'h0, 32'h0);
    check_eq("sw_m2use", {31'h0, M2Use}, 32'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
